// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and flush controller.
// Detects load-use hazards across the integer and float register files,
// holds the front of the pipe while a multi-cycle float op occupies EX,
// and squashes wrong-path instructions on a branch mispredict resolved in EX.
// Saturating counters track stall cycles and mispredict flushes.
//
// Control timing: there is no handshake here. Every hazard output is a
// same-cycle combinational decision from the current state and inputs. The
// pipeline registers consume these controls on the next rising edge of clk,
// which is also when this block's own state advances.
module hazard_ctrl #(
  parameter int FP_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       if_id_register_rs1,
  input  logic [4:0]       if_id_register_rs2,
  input  logic             if_id_rs1_sel,
  input  logic             if_id_rs2_sel,
  input  logic [4:0]       id_ex_register_rd,
  input  logic             id_ex_rd_sel,
  input  logic             id_ex_memread,
  input  logic             id_ex_float_start,
  input  logic             ex_mispredict,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             stall,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int CW = $clog2(FP_LAT) + 1;

  typedef enum logic {
    IDLE    = 1'b0,
    FP_WAIT = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          fp_done;

  logic rd_is_x0;
  logic rs1_hit;
  logic rs2_hit;
  logic lu;
  logic fp_trig;

  // Load-use detection; integer x0 is hard-wired and never creates a hazard,
  // while float f0 is a real register and does.
  always_comb begin
    rd_is_x0 = (id_ex_rd_sel == 1'b0) && (id_ex_register_rd == 5'd0);
    rs1_hit  = (if_id_register_rs1 == id_ex_register_rd) &&
               (if_id_rs1_sel == id_ex_rd_sel) && !rd_is_x0;
    rs2_hit  = (if_id_register_rs2 == id_ex_register_rd) &&
               (if_id_rs2_sel == id_ex_rd_sel) && !rd_is_x0;
    lu       = id_ex_memread && (rs1_hit || rs2_hit);
    // fp_done masks the cycle after a wait, when the same op is still in ID/EX
    fp_trig  = id_ex_float_start && !fp_done && (FP_LAT > 1);
  end

  // Hazard outputs: priority decision from state and inputs, zero in reset
  always_comb begin
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (ex_mispredict) begin
            if_id_flush = 1'b1;
            flush       = 1'b1;
          end else if (fp_trig) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            stall       = 1'b1;
          end else if (lu) begin
            // one bubble into ID/EX while the front of the pipe holds
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            flush       = 1'b1;
          end
        end
        FP_WAIT: begin
          if (ex_mispredict) begin
            if_id_flush = 1'b1;
            flush       = 1'b1;
          end else begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            stall       = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM, float-wait countdown, fp_done flag and saturating event counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      fp_done      <= 1'b0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      fp_done <= 1'b0;
      if (pc_stall && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (if_id_flush && (flush_events != {CNT_W{1'b1}}))
        flush_events <= flush_events + CNT_W'(1);
      case (state)
        IDLE: begin
          if (!ex_mispredict && fp_trig) begin
            if (FP_LAT == 2) begin
              fp_done <= 1'b1;
            end else begin
              state <= FP_WAIT;
              cnt   <= CW'(FP_LAT - 2);
            end
          end
        end
        FP_WAIT: begin
          if (ex_mispredict) begin
            state   <= IDLE;
            cnt     <= '0;
            fp_done <= 1'b0;
          end else if (cnt == CW'(1)) begin
            state   <= IDLE;
            fp_done <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: three hazard_ctrl instances (FP_LAT 4, 1 and 2; the
// FP_LAT=2 one uses 4-bit counters) share one set of inputs. The driver
// applies directed vectors and pushes the hand-computed expected outputs;
// a monitor on the falling edge pops and compares.
module tb_hazard_ctrl;

  localparam int W = 15 + 32 * 4 + 8;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0] rs1, rs2, rd;
  logic       rs1_sel, rs2_sel, rd_sel;
  logic       memread, fstart, mis;

  logic        ps4, is4, if4, st4, fl4;
  logic        ps1, is1, if1, st1, fl1;
  logic        ps2, is2, if2, st2, fl2;
  logic [31:0] sc4_o, fe4_o, sc1_o, fe1_o;
  logic [3:0]  sc2_o, fe2_o;

  hazard_ctrl #(.FP_LAT(4), .CNT_W(32)) dut4 (
    .clk(clk), .reset(reset),
    .if_id_register_rs1(rs1), .if_id_register_rs2(rs2),
    .if_id_rs1_sel(rs1_sel), .if_id_rs2_sel(rs2_sel),
    .id_ex_register_rd(rd), .id_ex_rd_sel(rd_sel),
    .id_ex_memread(memread), .id_ex_float_start(fstart),
    .ex_mispredict(mis),
    .pc_stall(ps4), .if_id_stall(is4), .if_id_flush(if4),
    .stall(st4), .flush(fl4),
    .stall_cycles(sc4_o), .flush_events(fe4_o)
  );

  hazard_ctrl #(.FP_LAT(1), .CNT_W(32)) dut1 (
    .clk(clk), .reset(reset),
    .if_id_register_rs1(rs1), .if_id_register_rs2(rs2),
    .if_id_rs1_sel(rs1_sel), .if_id_rs2_sel(rs2_sel),
    .id_ex_register_rd(rd), .id_ex_rd_sel(rd_sel),
    .id_ex_memread(memread), .id_ex_float_start(fstart),
    .ex_mispredict(mis),
    .pc_stall(ps1), .if_id_stall(is1), .if_id_flush(if1),
    .stall(st1), .flush(fl1),
    .stall_cycles(sc1_o), .flush_events(fe1_o)
  );

  hazard_ctrl #(.FP_LAT(2), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset),
    .if_id_register_rs1(rs1), .if_id_register_rs2(rs2),
    .if_id_rs1_sel(rs1_sel), .if_id_rs2_sel(rs2_sel),
    .id_ex_register_rd(rd), .id_ex_rd_sel(rd_sel),
    .id_ex_memread(memread), .id_ex_float_start(fstart),
    .ex_mispredict(mis),
    .pc_stall(ps2), .if_id_stall(is2), .if_id_flush(if2),
    .stall(st2), .flush(fl2),
    .stall_cycles(sc2_o), .flush_events(fe2_o)
  );

  // hazard bit order: {pc_stall, if_id_stall, if_id_flush, stall, flush}
  localparam logic [4:0] Z = 5'b00000;
  localparam logic [4:0] L = 5'b11001;  // load-use bubble
  localparam logic [4:0] S = 5'b11010;  // float hold
  localparam logic [4:0] F = 5'b00101;  // mispredict flush

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           failures = 0;

  // expected counter model
  logic [31:0] sc4, fe4, sc1, fe1;
  logic [3:0]  sc2, fe2;

  function automatic logic [31:0] inc32(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  function automatic logic [3:0] inc4(input logic [3:0] v, input logic en);
    return (en && v != 4'hF) ? v + 4'd1 : v;
  endfunction

  task automatic zero_model();
    sc4 = '0; fe4 = '0; sc1 = '0; fe1 = '0; sc2 = '0; fe2 = '0;
  endtask

  // push the expectation for the current cycle, advance the model, next cycle
  task automatic step(input string nm, input logic [4:0] e4,
                      input logic [4:0] e1, input logic [4:0] e2);
    exp_q.push_back({e4, e1, e2, sc4, fe4, sc1, fe1, sc2, fe2});
    name_q.push_back(nm);
    sc4 = inc32(sc4, e4[4]); fe4 = inc32(fe4, e4[2]);
    sc1 = inc32(sc1, e1[4]); fe1 = inc32(fe1, e1[2]);
    sc2 = inc4(sc2, e2[4]);  fe2 = inc4(fe2, e2[2]);
    @(posedge clk); #1;
  endtask

  task automatic step_all(input string nm, input logic [4:0] e);
    step(nm, e, e, e);
  endtask

  task automatic set_ld(input logic mr, input logic [4:0] d, input logic ds,
                        input logic [4:0] a, input logic as_,
                        input logic [4:0] b, input logic bs);
    memread = mr; rd = d; rd_sel = ds;
    rs1 = a; rs1_sel = as_; rs2 = b; rs2_sel = bs;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    zero_model();
    step_all("in_reset", Z);
    step_all("in_reset", Z);
    reset = 1'b0;
  endtask

  // monitor: every cycle with a pending expectation is compared
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {ps4, is4, if4, st4, fl4, ps1, is1, if1, st1, fl1,
            ps2, is2, if2, st2, fl2, sc4_o, fe4_o, sc1_o, fe1_o, sc2_o, fe2_o};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s actual=%h required=%h", nm, a, e);
      end
    end
  end

  // driver
  initial begin
    reset = 1'b1; fstart = 1'b0; mis = 1'b0;
    set_ld(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    zero_model();
    @(posedge clk); #1;
    do_reset();

    // load-use on the integer file
    set_ld(1'b1, 5'd5, 1'b0, 5'd1, 1'b0, 5'd5, 1'b0);  step_all("lu_rs2", L);
    set_ld(1'b0, 5'd5, 1'b0, 5'd1, 1'b0, 5'd9, 1'b0);  step_all("lu_gone", Z);
    set_ld(1'b1, 5'd0, 1'b0, 5'd1, 1'b0, 5'd0, 1'b0);  step_all("lu_x0", Z);
    set_ld(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd31, 1'b0); step_all("lu_file_mismatch", Z);
    set_ld(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd31, 1'b0); step_all("lu_float_rs1", L);
    set_ld(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd31, 1'b0); step_all("lu_f0", L);
    set_ld(1'b0, 5'd5, 1'b0, 5'd5, 1'b0, 5'd5, 1'b0);  step_all("no_load", Z);

    // float hold with start held high
    set_ld(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    fstart = 1'b1;
    step("fp_c0", S, Z, S);
    step("fp_c1", S, Z, Z);
    step("fp_c2", S, Z, S);
    step("fp_done", Z, Z, Z);
    fstart = 1'b0;
    step_all("fp_after", Z);

    // float start together with load-use
    set_ld(1'b1, 5'd5, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0);
    fstart = 1'b1;
    step("fplu_c0", S, L, S);
    step("fplu_c1", S, L, L);
    step("fplu_c2", S, L, S);
    step("fplu_c3", L, L, L);
    fstart = 1'b0; memread = 1'b0;
    step_all("fplu_after", Z);

    // mispredict beats load-use, three back-to-back cycles
    set_ld(1'b1, 5'd5, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0);
    mis = 1'b1;
    step_all("mis_lu_c0", F);
    step_all("mis_lu_c1", F);
    step_all("mis_lu_c2", F);
    mis = 1'b0; memread = 1'b0;
    step_all("mis_after", Z);

    // mispredict while waiting on a float op
    fstart = 1'b1;
    step("mis_fp_c0", S, Z, S);
    mis = 1'b1;
    step_all("mis_fp_c1", F);
    mis = 1'b0; fstart = 1'b0;
    step_all("mis_fp_after", Z);

    // asynchronous reset in the second FP_WAIT cycle
    fstart = 1'b1;
    step("rst_fp_c0", S, Z, S);
    step("rst_fp_c1", S, Z, Z);
    #1 reset = 1'b1;
    zero_model();
    step_all("rst_mid_wait", Z);
    fstart = 1'b0;
    step_all("rst_hold", Z);
    reset = 1'b0;
    step_all("rst_released_idle", Z);
    step_all("rst_released_idle2", Z);
    fstart = 1'b1;
    step("rst_new_c0", S, Z, S);
    step("rst_new_c1", S, Z, Z);
    step("rst_new_c2", S, Z, S);
    step("rst_new_done", Z, Z, Z);
    fstart = 1'b0;
    step_all("rst_new_after", Z);

    // counter saturation on the 4-bit instance
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_ld(1'b1, 5'd7, 1'b0, 5'd7, 1'b0, 5'd0, 1'b0);
      step_all("sat_lu", L);
      memread = 1'b0;
      step_all("sat_gap", Z);
    end
    mis = 1'b1;
    for (int i = 0; i < 17; i++) step_all("sat_flush", F);
    mis = 1'b0;
    step_all("sat_final", Z);

    // drain the scoreboard
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
